// File: rtl/xor_stream_cipher_core.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | xor_stream_cipher_core: serial-load XOR stream cipher, framed output  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module xor_stream_cipher_core #(
    parameter int KEY_W = 8,
    parameter int MSG_W = 16
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iEn,
    input  logic       iSerial_in,
    input  logic       iLoad_key,
    input  logic       iLoad_msg,
    input  logic [1:0] iMode,
    output logic       oSerial_out,
    output logic       oSerial_start,
    output logic       oSerial_end,
    output logic       oBusy,
    output logic       oKey_valid,
    output logic       oErr
);

    localparam int KC_W = $clog2(KEY_W + 1);
    localparam int MC_W = $clog2(MSG_W + 2);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_LOAD_KEY = 2'd1;
    localparam logic [1:0] c_LOAD_MSG = 2'd2;
    localparam logic [1:0] c_XMIT     = 2'd3;

    localparam logic [KC_W-1:0] c_KEY_FULL = KC_W'(KEY_W);
    localparam logic [MC_W-1:0] c_MSG_FULL = MC_W'(MSG_W);
    localparam logic [MC_W-1:0] c_MSG_OVER = MC_W'(MSG_W + 1);
    localparam logic [MC_W-1:0] c_MSG_LAST = MC_W'(MSG_W - 1);

    logic [1:0]       r_state, w_state_nxt;
    logic [KEY_W-1:0] r_key, r_work, w_work_cur, w_work_shift, w_key_shift;
    logic [MSG_W-1:0] r_msg, w_msg_shift;
    logic [KC_W-1:0]  r_kcnt, w_kcnt_base, w_kcnt_inc;
    logic [MC_W-1:0]  r_mcnt, w_mcnt_base, w_mcnt_inc, r_bidx;
    logic [1:0]       r_mode, w_mode_cur;
    logic             w_key_load, w_msg_load, w_xmit_go, w_xmit_done, w_emit;
    logic             w_bit, w_fill;
    logic             w_out_nxt, w_start_nxt, w_end_nxt, w_busy_nxt, w_err_nxt;

    assign w_key_load = ((r_state == c_IDLE) && iLoad_key && !iLoad_msg) ||
                        ((r_state == c_LOAD_KEY) && iLoad_key);
    assign w_msg_load = ((r_state == c_IDLE) && iLoad_msg && !iLoad_key) ||
                        ((r_state == c_LOAD_MSG) && iLoad_msg);
    assign w_xmit_go  = (r_state == c_LOAD_MSG) && !iLoad_msg &&
                        (r_mcnt == c_MSG_FULL) && oKey_valid;
    assign w_xmit_done = (r_state == c_XMIT) && (r_bidx == c_MSG_FULL);
    assign w_emit      = w_xmit_go || ((r_state == c_XMIT) && !w_xmit_done);

    // Counters restart from zero whenever a load begins from IDLE
    assign w_kcnt_base = (r_state == c_IDLE) ? '0 : r_kcnt;
    assign w_kcnt_inc  = (w_kcnt_base == c_KEY_FULL) ? w_kcnt_base : w_kcnt_base + KC_W'(1);
    assign w_mcnt_base = (r_state == c_IDLE) ? '0 : r_mcnt;
    assign w_mcnt_inc  = (w_mcnt_base == c_MSG_OVER) ? w_mcnt_base : w_mcnt_base + MC_W'(1);

    assign w_key_shift = (r_key << 1) | KEY_W'(iSerial_in);
    assign w_msg_shift = (r_msg << 1) | MSG_W'(iSerial_in);

    // On the XMIT entry edge the first bit comes straight from the stored key
    assign w_work_cur = (r_state == c_XMIT) ? r_work : r_key;
    assign w_mode_cur = (r_state == c_XMIT) ? r_mode : iMode;
    assign w_bit      = r_msg[MSG_W-1] ^ w_work_cur[KEY_W-1];

    always_comb begin
        w_fill = w_work_cur[KEY_W-1];
        case (w_mode_cur)
            2'b01:   w_fill = w_bit;
            2'b10:   w_fill = r_msg[MSG_W-1];
            default: w_fill = w_work_cur[KEY_W-1];
        endcase
    end

    assign w_work_shift = (w_work_cur << 1) | KEY_W'(w_fill);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= c_IDLE;
        end else if (iEn) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (iLoad_key && !iLoad_msg)
                    w_state_nxt = c_LOAD_KEY;
                else if (iLoad_msg && !iLoad_key)
                    w_state_nxt = c_LOAD_MSG;
            end
            c_LOAD_KEY: if (!iLoad_key) w_state_nxt = c_IDLE;
            c_LOAD_MSG: if (!iLoad_msg) w_state_nxt = w_xmit_go ? c_XMIT : c_IDLE;
            c_XMIT:     if (w_xmit_done) w_state_nxt = c_IDLE;
            default:    w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_out_nxt   = w_emit ? w_bit : 1'b0;
        w_busy_nxt  = w_emit;
        w_start_nxt = w_xmit_go;
        w_end_nxt   = w_emit && (w_xmit_go ? (MSG_W == 1) : (r_bidx == c_MSG_LAST));
        w_err_nxt   = ((r_state == c_IDLE) && iLoad_key && iLoad_msg) ||
                      ((r_state == c_LOAD_MSG) && !iLoad_msg && !w_xmit_go);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_key         <= '0;
            r_work        <= '0;
            r_msg         <= '0;
            r_kcnt        <= '0;
            r_mcnt        <= '0;
            r_bidx        <= '0;
            r_mode        <= '0;
            oKey_valid    <= 1'b0;
            oSerial_out   <= 1'b0;
            oSerial_start <= 1'b0;
            oSerial_end   <= 1'b0;
            oBusy         <= 1'b0;
            oErr          <= 1'b0;
        end else if (iEn) begin
            oSerial_out   <= w_out_nxt;
            oSerial_start <= w_start_nxt;
            oSerial_end   <= w_end_nxt;
            oBusy         <= w_busy_nxt;
            oErr          <= w_err_nxt;
            if (w_key_load) begin
                r_key  <= w_key_shift;
                r_kcnt <= w_kcnt_inc;
                if (w_kcnt_inc == c_KEY_FULL)
                    oKey_valid <= 1'b1;
            end
            if (w_msg_load) begin
                r_msg  <= w_msg_shift;
                r_mcnt <= w_mcnt_inc;
            end
            if (w_emit) begin
                r_msg  <= r_msg << 1;
                r_work <= w_work_shift;
                r_bidx <= w_xmit_go ? MC_W'(1) : r_bidx + MC_W'(1);
            end
            if (w_xmit_go)
                r_mode <= iMode;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xor_stream_cipher_core.sv
`default_nettype none
// Directed self-checking bench for xor_stream_cipher_core (KEY_W=8, MSG_W=16).
module tb_xor_stream_cipher_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       sin = 1'b0;
    logic       lk = 1'b0;
    logic       lm = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       sout, sstart, send, busy, kvalid, err;

    int total = 0;
    int bad = 0;

    xor_stream_cipher_core #(.KEY_W(8), .MSG_W(16)) dut (
        .iClk(clk), .iRst(rst), .iEn(en), .iSerial_in(sin),
        .iLoad_key(lk), .iLoad_msg(lm), .iMode(mode),
        .oSerial_out(sout), .oSerial_start(sstart), .oSerial_end(send),
        .oBusy(busy), .oKey_valid(kvalid), .oErr(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_key(input logic [7:0] k, input int nbits);
        lk = 1'b1;
        for (int i = nbits - 1; i >= 0; i--) begin
            sin = k[i];
            step();
        end
        lk = 1'b0;
        step();
    endtask

    task automatic load_msg(input logic [31:0] m, input int nbits);
        lm = 1'b1;
        for (int i = nbits - 1; i >= 0; i--) begin
            sin = m[i];
            step();
        end
        lm = 1'b0;
        step();
    endtask

    task automatic expect_err(input string tag);
        chk({tag, "_err"}, {31'd0, err}, 32'd1);
        chk({tag, "_nostart"}, {30'd0, sstart, busy}, 32'd0);
        step();
        chk({tag, "_err_clear"}, {31'd0, err}, 32'd0);
    endtask

    // Streams one 16-bit frame; optional freeze or reset at a given bit index
    task automatic stream(input string tag, input logic [1:0] md, input logic [15:0] msg,
                          input logic [15:0] exp, input int freeze_at, input int rst_at);
        logic [15:0] got;
        logic        flag_ok;
        got = '0;
        flag_ok = 1'b1;
        mode = md;
        load_msg({16'd0, msg}, 16);
        mode = ~md;
        for (int k = 0; k < 16; k++) begin
            got[15-k] = sout;
            if (sstart !== (k == 0) || send !== (k == 15) || busy !== 1'b1)
                flag_ok = 1'b0;
            if (k == freeze_at) begin
                en = 1'b0;
                repeat (3) step();
                chk({tag, "_frozen"}, {30'd0, sout, busy}, {30'd0, exp[15-k], 1'b1});
                en = 1'b1;
            end
            if (k == rst_at) begin
                rst = 1'b1;
                step();
                chk({tag, "_rst_outs"}, {26'd0, sout, sstart, send, busy, kvalid, err}, 32'd0);
                rst = 1'b0;
                step();
                return;
            end
            step();
        end
        chk({tag, "_data"}, {16'd0, got}, {16'd0, exp});
        chk({tag, "_framing"}, {31'd0, flag_ok}, 32'd1);
        chk({tag, "_after"}, {29'd0, sstart, send, busy}, 32'd0);
    endtask

    initial begin
        repeat (2) step();
        chk("reset_outs", {26'd0, sout, sstart, send, busy, kvalid, err}, 32'd0);
        rst = 1'b0;
        step();

        load_msg(32'h3C0F, 16);
        expect_err("nokey");

        load_key(8'h05, 4);
        chk("shortkey_valid", {30'd0, kvalid, err}, 32'd0);

        load_key(8'hA5, 8);
        chk("key_valid", {31'd0, kvalid}, 32'd1);

        stream("m00_a", 2'b00, 16'h3C0F, 16'h99AA, -1, -1);
        stream("m00_b", 2'b00, 16'h0000, 16'hA5A5, -1, -1);
        stream("m01", 2'b01, 16'h3C0F, 16'h9996, -1, -1);
        stream("m10", 2'b10, 16'h9996, 16'h3C0F, -1, -1);
        stream("m11", 2'b11, 16'h3C0F, 16'h99AA, -1, -1);

        load_msg(32'h0000_03AB, 10);
        expect_err("msg10");
        load_msg(32'h0001_3C0F, 17);
        expect_err("msg17");

        lk = 1'b1;
        lm = 1'b1;
        step();
        lk = 1'b0;
        lm = 1'b0;
        expect_err("bothloads");

        stream("freeze", 2'b00, 16'h3C0F, 16'h99AA, 5, -1);

        stream("rstmid", 2'b00, 16'h3C0F, 16'h99AA, -1, 9);
        load_msg(32'h3C0F, 16);
        expect_err("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
